// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Drives every input code of an N_IN-input combinational block, holds each
//   code for SETTLE cycles, samples the block's output, and publishes the
//   captured truth table with its minterm count and a one-cycle done pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      request a scan (only looked at while idle)
//   abort      cancel a scan in progress (no done, table_out kept)
//   y_in       output of the block under scan
//   abc_out    input code driven to the block, MSB is A
//   busy       high while a scan is in progress
//   done       one-cycle pulse when table_out/ones_cnt update
//   table_out  bit i = y_in captured while abc_out == i
//   ones_cnt   number of ones in table_out
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   y_in,
  output logic [N_IN-1:0]        abc_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          ones_cnt
);

  localparam int CODES = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  CODE_LAST = N_IN'(CODES - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CODES-1:0]     shadow, shadow_n;
  logic [N_IN-1:0]      abc_n;
  logic                 busy_n;
  logic                 done_n;
  logic [CODES-1:0]     tbl_n;
  logic [N_IN:0]        ones_n;
  logic [CODES-1:0]     captured;

  function automatic logic [N_IN:0] popcount(input logic [CODES-1:0] v);
    logic [N_IN:0] s;
    s = '0;
    for (int i = 0; i < CODES; i++) begin
      s = s + (N_IN+1)'(v[i]);
    end
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      abc_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      ones_cnt  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shadow    <= shadow_n;
      abc_out   <= abc_n;
      busy      <= busy_n;
      done      <= done_n;
      table_out <= tbl_n;
      ones_cnt  <= ones_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    abc_n    = abc_out;
    busy_n   = busy;
    done_n   = 1'b0;
    tbl_n    = table_out;
    ones_n   = ones_cnt;

    // Shadow table with the current sample folded in; used both for the
    // running capture and, on the last code, as the published table.
    captured          = shadow;
    captured[abc_out] = y_in;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SCAN;
          abc_n    = '0;
          cnt_n    = '0;
          shadow_n = '0;
          busy_n   = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          abc_n   = '0;
          cnt_n   = '0;
        end else if (cnt != CNT_LAST) begin
          cnt_n = cnt + 1'b1;
        end else if (abc_out != CODE_LAST) begin
          shadow_n = captured;
          abc_n    = abc_out + 1'b1;
          cnt_n    = '0;
        end else begin
          // Last code: publish the whole table at once so partial
          // results are never visible on table_out.
          tbl_n   = captured;
          ones_n  = popcount(captured);
          done_n  = 1'b1;
          busy_n  = 1'b0;
          abc_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst, start, abort, y_in;
  logic [2:0] abc_out;
  logic       busy, done;
  logic [7:0] table_out;
  logic [3:0] ones_cnt;

  logic       start1, abort1, y1;
  logic [2:0] abc1;
  logic       busy1, done1;
  logic [7:0] table1;
  logic [3:0] ones1;

  int mode;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] t;
    logic [3:0] n;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   bcyc;
  bit   abc_ok, got;

  always #5 clk = ~clk;

  function automatic logic yfunc(input int m, input logic [2:0] c);
    case (m)
      0:       return (c[2] & c[1]) | (c[2] & c[0]) | (c[1] & c[0]);
      1:       return c[2] ^ c[1] ^ c[0];
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb y_in = yfunc(mode, abc_out);
  always_comb y1   = yfunc(0, abc1);

  truth_table_scanner #(.N_IN(3), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in),
    .abc_out(abc_out), .busy(busy), .done(done),
    .table_out(table_out), .ones_cnt(ones_cnt)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .y_in(y1),
    .abc_out(abc1), .busy(busy1), .done(done1),
    .table_out(table1), .ones_cnt(ones1)
  );

  task automatic push_exp(input int m);
    exp_t x;
    case (m)
      0:       begin x.t = 8'b11101000; x.n = 4'd4; end
      1:       begin x.t = 8'b10010110; x.n = 4'd4; end
      2:       begin x.t = 8'hFF;       x.n = 4'd8; end
      default: begin x.t = 8'h00;       x.n = 4'd0; end
    endcase
    sb.push_back(x);
  endtask

  // Waits (bounded) for done on the SETTLE=2 instance, counting busy cycles
  // and tracking whether abc_out followed the expected 2-cycle staircase.
  task automatic wait_done(input bit hold, output int bc, output bit ok, output bit seen);
    bc = 0; ok = 1'b1; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) begin
        if (abc_out !== 3'(bc / 2)) ok = 1'b0;
        bc++;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({abc_out, busy, done, table_out, ones_cnt} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0", {abc_out, busy, done, table_out, ones_cnt});
    end
    checks++;
    if ({abc1, busy1, done1, table1, ones1} !== 17'd0) begin
      errors++; $display("FAIL reset_outputs_s1: got %h required 0", {abc1, busy1, done1, table1, ones1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scans();
    for (int m = 0; m < 4; m++) begin
      mode = m; start = 1'b1; push_exp(m);
      wait_done(1'b0, bcyc, abc_ok, got);
      e = sb.pop_front();
      checks++;
      if (!got) begin
        errors++; $display("FAIL scan%0d_done: no done within budget, required a done pulse", m);
      end else begin
        checks++;
        if (table_out !== e.t) begin errors++; $display("FAIL scan%0d_table: got %b required %b", m, table_out, e.t); end
        checks++;
        if (ones_cnt !== e.n) begin errors++; $display("FAIL scan%0d_ones: got %0d required %0d", m, ones_cnt, e.n); end
        checks++;
        if (bcyc !== 16) begin errors++; $display("FAIL scan%0d_busy_cycles: got %0d required 16", m, bcyc); end
        checks++;
        if (!abc_ok) begin errors++; $display("FAIL scan%0d_abc_steps: got bad sequence required 0..7 held 2 cycles", m); end
        checks++;
        if (busy !== 1'b0 || abc_out !== 3'd0) begin
          errors++; $display("FAIL scan%0d_done_state: got busy=%b abc=%0d required busy=0 abc=0", m, busy, abc_out);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL scan%0d_done_width: got done=%b required 0", m, done); end
    end
  endtask

  task automatic test_back_to_back();
    mode = 0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(0);
      wait_done(1'b1, bcyc, abc_ok, got);
      e = sb.pop_front();
      checks++;
      if (!got) begin
        errors++; $display("FAIL b2b%0d_done: no done within budget, required a done pulse", k);
      end else begin
        checks++;
        if (table_out !== e.t || ones_cnt !== e.n) begin
          errors++; $display("FAIL b2b%0d_table: got %b/%0d required %b/%0d", k, table_out, ones_cnt, e.t, e.n);
        end
        checks++;
        if (bcyc !== 16 || !abc_ok) begin
          errors++; $display("FAIL b2b%0d_busy: got %0d cycles abc_ok=%b required 16 cycles abc_ok=1", k, bcyc, abc_ok);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_abort();
    bit seen_done;
    mode = 1; start = 1'b1; push_exp(1);
    wait_done(1'b0, bcyc, abc_ok, got);
    e = sb.pop_front();
    checks++;
    if (!got || table_out !== e.t) begin
      errors++; $display("FAIL abort_pre_parity: got done=%b table=%b required done=1 table=%b", got, table_out, e.t);
    end
    @(negedge clk);
    mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && abc_out !== 3'd5; c++) @(negedge clk);
    checks++;
    if (abc_out !== 3'd5) begin errors++; $display("FAIL abort_reach5: got abc=%0d required 5", abc_out); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || abc_out !== 3'd0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%b abc=%0d done=%b required 0/0/0", busy, abc_out, done);
    end
    checks++;
    if (table_out !== 8'b10010110 || ones_cnt !== 4'd4) begin
      errors++; $display("FAIL abort_table_kept: got %b/%0d required 10010110/4", table_out, ones_cnt);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_quiet: got activity after abort required none"); end
  endtask

  task automatic test_idle_abort();
    abort = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || table_out !== 8'b10010110) begin
      errors++; $display("FAIL idle_abort: got busy=%b table=%b required 0/10010110", busy, table_out);
    end
    mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL start_beats_abort: got busy=%b required 1", busy); end
    push_exp(0);
    wait_done(1'b0, bcyc, abc_ok, got);
    e = sb.pop_front();
    checks++;
    // One busy cycle was already observed above, so 15 remain.
    if (!got || bcyc !== 15 || table_out !== e.t) begin
      errors++; $display("FAIL start_abort_scan: got done=%b busy=%0d table=%b required 1/15/%b", got, bcyc, table_out, e.t);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && abc_out !== 3'd3; c++) @(negedge clk);
    checks++;
    if (abc_out !== 3'd3) begin errors++; $display("FAIL areset_reach3: got abc=%0d required 3", abc_out); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({abc_out, busy, done, table_out, ones_cnt} !== 17'd0) begin
      errors++; $display("FAIL areset_immediate: got %h required 0", {abc_out, busy, done, table_out, ones_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; push_exp(0);
    wait_done(1'b0, bcyc, abc_ok, got);
    e = sb.pop_front();
    checks++;
    if (!got || bcyc !== 16 || !abc_ok || table_out !== e.t || ones_cnt !== e.n) begin
      errors++; $display("FAIL areset_rescan: got done=%b busy=%0d abc_ok=%b table=%b ones=%0d required 1/16/1/%b/%0d", got, bcyc, abc_ok, table_out, ones_cnt, e.t, e.n);
    end
    @(negedge clk);
  endtask

  task automatic test_settle1();
    int  bc;
    bit  ok, seen;
    bc = 0; ok = 1'b1; seen = 1'b0;
    start1 = 1'b1; push_exp(0);
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) seen = 1'b1;
      else if (busy1) begin
        if (abc1 !== 3'(bc)) ok = 1'b0;
        bc++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++; $display("FAIL settle1_done: no done within budget, required a done pulse");
    end else begin
      checks++;
      if (bc !== 8 || !ok) begin errors++; $display("FAIL settle1_busy: got %0d cycles abc_ok=%b required 8/1", bc, ok); end
      checks++;
      if (table1 !== e.t || ones1 !== e.n) begin
        errors++; $display("FAIL settle1_table: got %b/%0d required %b/%0d", table1, ones1, e.t, e.n);
      end
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL settle1_after: got done=%b busy=%b required 0/0", done1, busy1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0; abort1 = 1'b0; mode = 0;
    test_reset();
    test_scans();
    test_back_to_back();
    test_abort();
    test_idle_abort();
    test_async_reset();
    test_settle1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
